ddr3_mcb_cmd_dec: RTL and testbench
===================================

// Module: ddr3_mcb_cmd_dec
// PURPOSE
// - Receive side of the DDR3 command/address bus driven by the MCB signal-FF stage.
// - Decodes {cs_n,ras_n,cas_n,we_n}/ba/addr into registered one-cycle event pulses.
// - Tracks per-bank open-row state, captures MR0..MR3 writes and flags protocol violations.
// - Used as the bus monitor/responder in DRAM models and as an on-chip checker.
// PARAMETERS
// - SDR_B_W  3   bank address width; NB = 2**SDR_B_W banks
// - SDR_A_W  14  address bus width (row address width)
// - MCB_C_W  10  decoded column width (addr[9:0])
// - T_RCD    6   ACT->RD/WR minimum clocks (used only with DDR3_DEC_TCHK_EN)
// - T_RP     6   PRE->ACT minimum clocks (used only with DDR3_DEC_TCHK_EN)
// PORTS
// - ddr3_mcb_clk   in   1        clock
// - ddr3_mcb_rst_n in   1        async active-low reset
// - ddr3_cke       in   1        clock enable; commands are ignored while low
// - ddr3_rst       in   1        DRAM reset, active low; low clears bank and MR state
// - ddr3_cs_n/ras_n/cas_n/we_n  in  1 each  command bus
// - ddr3_ba        in   SDR_B_W  bank address
// - ddr3_addr      in   SDR_A_W  row/column/MR address
// - d_act,d_rd,d_wr,d_pre,d_prea,d_ref,d_lmr,d_zq  out  1 each  decoded event pulses
// - d_ba           out  SDR_B_W  bank of the last decoded command
// - d_ra           out  SDR_A_W  row of the last ACT
// - d_ca           out  MCB_C_W  column of the last RD/WR
// - d_bank_open    out  NB       1 = bank ACTIVE
// - mr_sel         in   2        MR readback select
// - mr_data        out  SDR_A_W  MRn[mr_sel]; combinational readback
// - err_clr        in   1        clear the sticky error
// - err_flag       out  1        sticky protocol error
// - err_code       out  3        code of the first error since the last clear
// BEHAVIOUR
// - Reset: all pulses, d_ba/d_ra/d_ca, d_bank_open, MR0..3, err_flag and err_code = 0; all banks IDLE.
// - Commands are sampled only when cke=1 and rst=1; cs_n=1 is DSEL and is treated as NOP.
// - Encodings: 0000 LMR, 0001 REF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD, 0110 ZQ, 0111 NOP.
// - PRE with addr[10]=1 is PREA: d_prea pulses and all banks are precharged. Otherwise d_pre pulses and only ba is precharged.
// - Latency: each pulse and its d_* fields register exactly 1 clock after the command edge.
// - d_ba/d_ra/d_ca hold their value between commands.
// - LMR: MR[ba[1:0]] <= addr, visible on mr_data the next cycle; ba[2]=1 sets error 6.
// - Per-bank FSM:
//   - IDLE -ACT-> ACTIVATING.
//   - ACTIVATING -cnt==T_RCD-1-> ACTIVE.
//   - ACTIVE -PRE/PREA-> PRECHARGING.
//   - PRECHARGING -cnt==T_RP-1-> IDLE.
//   - PRE to an IDLE bank is legal and has no effect.
// - Error codes:
//   - 1: ACT to a bank not IDLE.
//   - 2: RD/WR to a bank IDLE or PRECHARGING.
//   - 3: REF with any bank not IDLE.
//   - 4: RD/WR in ACTIVATING (tRCD).
//   - 5: ACT in PRECHARGING (tRP).
//   - 6: LMR to an illegal MR.
// - An erroneous command still emits its pulse; the bank state does not change on error.
// - err_code latches the first error only. err_clr and a new error in the same cycle: the new error wins (flag=1, code=new).
// - ddr3_rst low mid-operation: banks go to IDLE and MRs clear next clock; err state is kept.
// - cke low: the bank FSM timers keep counting; no decode.
// CONFIGURATION
// - `define DDR3_DEC_TCHK_EN: ACTIVATING/PRECHARGING states with T_RCD/T_RP counters; codes 4 and 5 are active.
// - Without the macro: ACT goes straight to ACTIVE, PRE/PREA go straight to IDLE, no counters, codes 4/5 are never raised.
// TESTING
// - Reset, then NOP/DSEL only -> all outputs 0, d_bank_open=0, err_flag=0.
// - LMR ba=2 addr=0x0018, then mr_sel=2 -> d_lmr pulses 1 clk later; mr_data=0x0018.
// - ACT ba=3 row=0x1A5; RD ba=3 col=0x040 after T_RCD clocks -> d_act, d_ra=0x1A5, d_bank_open[3]=1; d_rd, d_ca=0x040, no error.
// - RD ba=5 with bank 5 idle -> d_rd pulses, err_flag=1, err_code=2. A second ACT to open bank 3 keeps code=2. err_clr clears the flag.
// - ACT banks 0 and 1, PRE addr[10]=1, REF 1 clk later -> d_prea; with TCHK err_code=3, without TCHK no error and d_bank_open=0.
// - TCHK: ACT ba=0 then RD ba=0 after 2 clocks -> err_code=4. Drive ddr3_rst=0 mid-ACTIVATING -> bank 0 IDLE, MRs=0, err_flag held.

Source files
------------

// File: rtl/ddr3_mcb_cmd_dec_if.sv
// rtl/ddr3_mcb_cmd_dec_if.sv - DDR3 command/address bus as seen by the decoder
interface ddr3_mcb_cmd_dec_if #(
    parameter int SDR_B_W = 3,
    parameter int SDR_A_W = 14
);
    logic               ddr3_cke;
    logic               ddr3_rst;
    logic               ddr3_cs_n;
    logic               ddr3_ras_n;
    logic               ddr3_cas_n;
    logic               ddr3_we_n;
    logic [SDR_B_W-1:0] ddr3_ba;
    logic [SDR_A_W-1:0] ddr3_addr;

    modport master (
        output ddr3_cke, ddr3_rst, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n,
               ddr3_ba, ddr3_addr
    );

    modport slave (
        input  ddr3_cke, ddr3_rst, ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n,
               ddr3_ba, ddr3_addr
    );
endinterface

// File: rtl/ddr3_mcb_cmd_dec.sv
// rtl/ddr3_mcb_cmd_dec.sv - DDR3 command decoder, bank tracker, MR capture and checker
// Optional tRCD/tRP timing states and checks: define DDR3_DEC_TCHK_EN.
module ddr3_mcb_cmd_dec #(
    parameter int SDR_B_W = 3,
    parameter int SDR_A_W = 14,
    parameter int MCB_C_W = 10,
    parameter int T_RCD   = 6,
    parameter int T_RP    = 6
) (
    input  logic                  ddr3_mcb_clk,
    input  logic                  ddr3_mcb_rst_n,
    ddr3_mcb_cmd_dec_if.slave     cmd,
    output logic                  d_act,
    output logic                  d_rd,
    output logic                  d_wr,
    output logic                  d_pre,
    output logic                  d_prea,
    output logic                  d_ref,
    output logic                  d_lmr,
    output logic                  d_zq,
    output logic [SDR_B_W-1:0]    d_ba,
    output logic [SDR_A_W-1:0]    d_ra,
    output logic [MCB_C_W-1:0]    d_ca,
    output logic [2**SDR_B_W-1:0] d_bank_open,
    input  logic [1:0]            mr_sel,
    output logic [SDR_A_W-1:0]    mr_data,
    input  logic                  err_clr,
    output logic                  err_flag,
    output logic [2:0]            err_code
);
    localparam int NB = 2**SDR_B_W;

    localparam logic [2:0] OP_LMR = 3'b000;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_ACT = 3'b011;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_ZQ  = 3'b110;

    localparam logic [2:0] E_NONE = 3'd0;
    localparam logic [2:0] E_ACT  = 3'd1;
    localparam logic [2:0] E_RW   = 3'd2;
    localparam logic [2:0] E_REF  = 3'd3;
    localparam logic [2:0] E_RCD  = 3'd4;
    localparam logic [2:0] E_RP   = 3'd5;
    localparam logic [2:0] E_MR   = 3'd6;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ACTIVATING,
        B_ACTIVE,
        B_PRECHARGING
    } bank_state_t;

    bank_state_t               bank_st  [NB];
    bank_state_t               bank_nxt [NB];
    logic [3:0][SDR_A_W-1:0]   mr;
    logic [2:0]                op;
    logic                      cmd_en;
    logic                      any_busy;
    logic [2:0]                new_err;
    bank_state_t               cur;

    // DSEL (cs_n=1) decodes as nothing, exactly like NOP
    assign cmd_en  = cmd.ddr3_cke && cmd.ddr3_rst && !cmd.ddr3_cs_n;
    assign op      = {cmd.ddr3_ras_n, cmd.ddr3_cas_n, cmd.ddr3_we_n};
    assign cur     = bank_st[cmd.ddr3_ba];
    assign mr_data = mr[mr_sel];

    for (genvar g = 0; g < NB; g++) begin : g_open
        assign d_bank_open[g] = (bank_st[g] == B_ACTIVE);
    end

`ifdef DDR3_DEC_TCHK_EN
    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
    localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);

    logic [CNT_W-1:0] cnt     [NB];
    logic [CNT_W-1:0] cnt_nxt [NB];
    logic             rcd_done;
    logic             rp_done;

    // A command landing on the final timer count is legal: the bank finishes its transition on that edge
    assign rcd_done = (cur == B_ACTIVATING)  && (cnt[cmd.ddr3_ba] == RCD_LAST);
    assign rp_done  = (cur == B_PRECHARGING) && (cnt[cmd.ddr3_ba] == RP_LAST);
`else
    localparam int unused_tparams = T_RCD + T_RP;
`endif

    always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
        if (!ddr3_mcb_rst_n) begin
            for (int b = 0; b < NB; b++) begin
                bank_st[b] <= B_IDLE;
`ifdef DDR3_DEC_TCHK_EN
                cnt[b]     <= '0;
`endif
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                bank_st[b] <= bank_nxt[b];
`ifdef DDR3_DEC_TCHK_EN
                cnt[b]     <= cnt_nxt[b];
`endif
            end
        end
    end

    always_comb begin
        bank_nxt = bank_st;
        new_err  = E_NONE;
        any_busy = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (bank_st[b] != B_IDLE) any_busy = 1'b1;
        end
`ifdef DDR3_DEC_TCHK_EN
        cnt_nxt = cnt;
        // Timers run regardless of cke; only ddr3_rst below overrides them
        for (int b = 0; b < NB; b++) begin
            if (bank_st[b] == B_ACTIVATING) begin
                if (cnt[b] == RCD_LAST) bank_nxt[b] = B_ACTIVE;
                else                    cnt_nxt[b]  = cnt[b] + 1'b1;
            end else if (bank_st[b] == B_PRECHARGING) begin
                if (cnt[b] == RP_LAST)  bank_nxt[b] = B_IDLE;
                else                    cnt_nxt[b]  = cnt[b] + 1'b1;
            end
        end
`endif
        if (!cmd.ddr3_rst) begin
            for (int b = 0; b < NB; b++) bank_nxt[b] = B_IDLE;
        end else if (cmd_en) begin
            case (op)
                OP_ACT: begin
`ifdef DDR3_DEC_TCHK_EN
                    if (cur == B_IDLE || rp_done) begin
                        bank_nxt[cmd.ddr3_ba] = B_ACTIVATING;
                        cnt_nxt[cmd.ddr3_ba]  = '0;
                    end else if (cur == B_PRECHARGING) begin
                        new_err = E_RP;
                    end else begin
                        new_err = E_ACT;
                    end
`else
                    if (cur == B_IDLE) bank_nxt[cmd.ddr3_ba] = B_ACTIVE;
                    else               new_err = E_ACT;
`endif
                end
                OP_RD, OP_WR: begin
`ifdef DDR3_DEC_TCHK_EN
                    if (cur == B_ACTIVATING && !rcd_done) new_err = E_RCD;
                    else if (cur != B_ACTIVE && !rcd_done) new_err = E_RW;
`else
                    if (cur != B_ACTIVE) new_err = E_RW;
`endif
                end
                OP_PRE: begin
                    for (int b = 0; b < NB; b++) begin
                        if (cmd.ddr3_addr[10] || b == int'(cmd.ddr3_ba)) begin
`ifdef DDR3_DEC_TCHK_EN
                            if (bank_st[b] == B_ACTIVE || bank_st[b] == B_ACTIVATING) begin
                                bank_nxt[b] = B_PRECHARGING;
                                cnt_nxt[b]  = '0;
                            end
`else
                            bank_nxt[b] = B_IDLE;
`endif
                        end
                    end
                end
                OP_REF: begin
                    if (any_busy) new_err = E_REF;
                end
                OP_LMR: begin
                    if ((cmd.ddr3_ba >> 2) != '0) new_err = E_MR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
        if (!ddr3_mcb_rst_n) begin
            d_act    <= 1'b0;
            d_rd     <= 1'b0;
            d_wr     <= 1'b0;
            d_pre    <= 1'b0;
            d_prea   <= 1'b0;
            d_ref    <= 1'b0;
            d_lmr    <= 1'b0;
            d_zq     <= 1'b0;
            d_ba     <= '0;
            d_ra     <= '0;
            d_ca     <= '0;
            mr       <= '0;
            err_flag <= 1'b0;
            err_code <= E_NONE;
        end else begin
            d_act  <= cmd_en && (op == OP_ACT);
            d_rd   <= cmd_en && (op == OP_RD);
            d_wr   <= cmd_en && (op == OP_WR);
            d_pre  <= cmd_en && (op == OP_PRE) && !cmd.ddr3_addr[10];
            d_prea <= cmd_en && (op == OP_PRE) &&  cmd.ddr3_addr[10];
            d_ref  <= cmd_en && (op == OP_REF);
            d_lmr  <= cmd_en && (op == OP_LMR);
            d_zq   <= cmd_en && (op == OP_ZQ);
            if (cmd_en && op != 3'b111) d_ba <= cmd.ddr3_ba;
            if (cmd_en && op == OP_ACT) d_ra <= cmd.ddr3_addr;
            if (cmd_en && (op == OP_RD || op == OP_WR)) d_ca <= cmd.ddr3_addr[MCB_C_W-1:0];

            if (!cmd.ddr3_rst) mr <= '0;
            else if (cmd_en && op == OP_LMR && new_err == E_NONE) mr[cmd.ddr3_ba[1:0]] <= cmd.ddr3_addr;

            // Error state survives ddr3_rst; a fresh error beats a same-cycle clear
            if (new_err != E_NONE) begin
                err_flag <= 1'b1;
                if (!err_flag || err_clr) err_code <= new_err;
            end else if (err_clr) begin
                err_flag <= 1'b0;
                err_code <= E_NONE;
            end
        end
    end
endmodule

// File: tb/tb_ddr3_mcb_cmd_dec.sv
// tb/tb_ddr3_mcb_cmd_dec.sv - directed-vector bench for ddr3_mcb_cmd_dec
module tb_ddr3_mcb_cmd_dec;
    localparam int T_RCD = 6;

    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_ZQ   = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DSEL = 4'b1000;

    localparam int P_ACT  = 'h80;
    localparam int P_RD   = 'h40;
    localparam int P_WR   = 'h20;
    localparam int P_PRE  = 'h10;
    localparam int P_PREA = 'h08;
    localparam int P_REF  = 'h04;
    localparam int P_LMR  = 'h02;
    localparam int P_ZQ   = 'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_act, d_rd, d_wr, d_pre, d_prea, d_ref, d_lmr, d_zq;
    logic [2:0]  d_ba;
    logic [13:0] d_ra;
    logic [9:0]  d_ca;
    logic [7:0]  d_bank_open;
    logic [1:0]  mr_sel = 2'd0;
    logic [13:0] mr_data;
    logic        err_clr = 1'b0;
    logic        err_flag;
    logic [2:0]  err_code;
    logic [7:0]  pulses;

    int n_cmp = 0;
    int n_bad = 0;

    ddr3_mcb_cmd_dec_if #(.SDR_B_W(3), .SDR_A_W(14)) bus ();

    ddr3_mcb_cmd_dec #(.SDR_B_W(3), .SDR_A_W(14), .MCB_C_W(10), .T_RCD(T_RCD), .T_RP(6)) dut (
        .ddr3_mcb_clk   (clk),
        .ddr3_mcb_rst_n (rst_n),
        .cmd            (bus.slave),
        .d_act          (d_act),
        .d_rd           (d_rd),
        .d_wr           (d_wr),
        .d_pre          (d_pre),
        .d_prea         (d_prea),
        .d_ref          (d_ref),
        .d_lmr          (d_lmr),
        .d_zq           (d_zq),
        .d_ba           (d_ba),
        .d_ra           (d_ra),
        .d_ca           (d_ca),
        .d_bank_open    (d_bank_open),
        .mr_sel         (mr_sel),
        .mr_data        (mr_data),
        .err_clr        (err_clr),
        .err_flag       (err_flag),
        .err_code       (err_code)
    );

    assign pulses = {d_act, d_rd, d_wr, d_pre, d_prea, d_ref, d_lmr, d_zq};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] c, input logic [2:0] ba, input logic [13:0] a);
        {bus.ddr3_cs_n, bus.ddr3_ras_n, bus.ddr3_cas_n, bus.ddr3_we_n} = c;
        bus.ddr3_ba   = ba;
        bus.ddr3_addr = a;
        @(posedge clk);
        #1;
        {bus.ddr3_cs_n, bus.ddr3_ras_n, bus.ddr3_cas_n, bus.ddr3_we_n} = C_DSEL;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(C_NOP, 3'd0, 14'd0);
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        cyc(C_NOP, 3'd0, 14'd0);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.ddr3_cke = 1'b1;
        bus.ddr3_rst = 1'b1;
        {bus.ddr3_cs_n, bus.ddr3_ras_n, bus.ddr3_cas_n, bus.ddr3_we_n} = C_DSEL;
        bus.ddr3_ba   = '0;
        bus.ddr3_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_pulses", 32'(pulses), 0);
        check("rst_fields", 32'({d_ba, d_ra, d_ca}), 0);
        check("rst_open", 32'(d_bank_open), 0);
        check("rst_err", 32'({err_flag, err_code}), 0);
        check("rst_mr0", 32'(mr_data), 0);

        cyc(C_DSEL, 3'd5, 14'h3FFF);
        cyc(C_NOP, 3'd5, 14'h3FFF);
        check("nop_pulses", 32'(pulses), 0);
        check("nop_state", 32'({d_ba, d_bank_open, err_flag}), 0);

        cyc(C_LMR, 3'd2, 14'h0018);
        check("lmr_pulse", 32'(pulses), P_LMR);
        check("lmr_ba", 32'(d_ba), 2);
        mr_sel = 2'd2; #1;
        check("mr2_data", 32'(mr_data), 'h18);
        mr_sel = 2'd0; #1;
        check("mr0_data", 32'(mr_data), 0);

        cyc(C_ACT, 3'd3, 14'h01A5);
        check("act_pulse", 32'(pulses), P_ACT);
        check("act_ra", 32'(d_ra), 'h1A5);
`ifdef DDR3_DEC_TCHK_EN
        check("act_open_tchk", 32'(d_bank_open), 0);
`else
        check("act_open", 32'(d_bank_open), 'h08);
`endif
        nops(T_RCD - 1);
        cyc(C_RD, 3'd3, 14'h0040);
        check("rd_pulse", 32'(pulses), P_RD);
        check("rd_ca", 32'(d_ca), 'h040);
        check("rd_open", 32'(d_bank_open), 'h08);
        check("rd_noerr", 32'(err_flag), 0);
        cyc(C_WR, 3'd3, 14'h0455);
        check("wr_pulse", 32'(pulses), P_WR);
        check("wr_ca_trunc", 32'(d_ca), 'h055);
        check("wr_ra_hold", 32'({d_ba, d_ra}), {3'd3, 14'h01A5});

        cyc(C_RD, 3'd5, 14'h0001);
        check("rd_idle_pulse", 32'(pulses), P_RD);
        check("rd_idle_err", 32'({err_flag, err_code}), {1'b1, 3'd2});
        cyc(C_ACT, 3'd3, 14'h0002);
        check("act_open_pulse", 32'(pulses), P_ACT);
        check("first_err_kept", 32'({err_flag, err_code}), {1'b1, 3'd2});
        check("err_no_state", 32'(d_bank_open), 'h08);
        clear_err;
        check("err_clr", 32'({err_flag, err_code}), 0);
        err_clr = 1'b1;
        cyc(C_ACT, 3'd3, 14'h0002);
        err_clr = 1'b0;
        check("clr_vs_new", 32'({err_flag, err_code}), {1'b1, 3'd1});
        clear_err;

        cyc(C_ZQ, 3'd1, 14'h0400);
        check("zq_pulse", 32'(pulses), P_ZQ);
        cyc(C_PRE, 3'd3, 14'h0000);
        check("pre_pulse", 32'(pulses), P_PRE);
        check("pre_closed", 32'(d_bank_open), 0);
        nops(T_RCD);

        cyc(C_ACT, 3'd0, 14'h0010);
        cyc(C_ACT, 3'd1, 14'h0011);
        nops(T_RCD);
        check("two_open", 32'(d_bank_open), 'h03);
        cyc(C_PRE, 3'd6, 14'h0400);
        check("prea_pulse", 32'(pulses), P_PREA);
        check("prea_closed", 32'(d_bank_open), 0);
        cyc(C_REF, 3'd0, 14'h0000);
        check("ref_pulse", 32'(pulses), P_REF);
`ifdef DDR3_DEC_TCHK_EN
        check("ref_busy_err", 32'({err_flag, err_code}), {1'b1, 3'd3});
`else
        check("ref_noerr", 32'({err_flag, err_code}), 0);
`endif
        clear_err;
        nops(T_RCD);

        cyc(C_LMR, 3'd4, 14'h1234);
        check("lmr_bad_pulse", 32'(pulses), P_LMR);
        check("lmr_bad_err", 32'({err_flag, err_code}), {1'b1, 3'd6});
        check("lmr_bad_nowr", 32'(mr_data), 0);
        clear_err;

        bus.ddr3_cke = 1'b0;
        cyc(C_ACT, 3'd2, 14'h0077);
        bus.ddr3_cke = 1'b1;
        check("cke_low_pulse", 32'(pulses), 0);
        check("cke_low_open", 32'(d_bank_open), 0);

`ifndef DDR3_DEC_TCHK_EN
        cyc(C_ACT, 3'd4, 14'h0005);
        cyc(C_RD, 3'd4, 14'h0006);
        check("no_rcd_check", 32'({err_flag, err_code}), 0);
        cyc(C_PRE, 3'd4, 14'h0000);
        cyc(C_ACT, 3'd4, 14'h0005);
        check("no_rp_check", 32'({err_flag, err_code, d_bank_open}), 'h10);
        cyc(C_PRE, 3'd4, 14'h0000);
`endif

        cyc(C_ACT, 3'd2, 14'h0020);
        nops(T_RCD);
        check("bank2_open", 32'(d_bank_open), 'h04);
        cyc(C_RD, 3'd7, 14'h0000);
        mr_sel = 2'd2; #1;
        check("mr2_before_rst", 32'(mr_data), 'h18);
        bus.ddr3_rst = 1'b0;
        cyc(C_ACT, 3'd5, 14'h0000);
        bus.ddr3_rst = 1'b1;
        check("drst_pulses", 32'(pulses), 0);
        check("drst_open", 32'(d_bank_open), 0);
        check("drst_mr2", 32'(mr_data), 0);
        check("drst_err_kept", 32'({err_flag, err_code}), {1'b1, 3'd2});
        clear_err;

`ifdef DDR3_DEC_TCHK_EN
        cyc(C_ACT, 3'd0, 14'h0030);
        nops(1);
        cyc(C_RD, 3'd0, 14'h0000);
        check("rcd_err", 32'({err_flag, err_code}), {1'b1, 3'd4});
        bus.ddr3_rst = 1'b0;
        cyc(C_NOP, 3'd0, 14'h0000);
        bus.ddr3_rst = 1'b1;
        check("rcd_rst_flag", 32'({err_flag, err_code}), {1'b1, 3'd4});
        clear_err;
        cyc(C_ACT, 3'd0, 14'h0031);
        check("act_after_drst", 32'(err_flag), 0);
        nops(T_RCD);
        check("tchk_open0", 32'(d_bank_open), 'h01);
        cyc(C_PRE, 3'd0, 14'h0000);
        cyc(C_ACT, 3'd0, 14'h0032);
        check("rp_err", 32'({err_flag, err_code}), {1'b1, 3'd5});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
